// File: rtl/gate_ex_pkg.sv
//------------------------------------------------------------------------------
// Module   : gate_ex_pkg
// Brief    : Shared types and helpers for the gate vector exerciser.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gate_ex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } gate_ex_state_e;

  localparam int C_DEFAULT_HOLD = 3;

  // Expected gate response: AND reduction of the low 'width' bits of vec.
  function automatic logic f_and_reduce(input logic [31:0] vec, input int width);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r = r & vec[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ex_hold_ctr.sv
//------------------------------------------------------------------------------
// Module   : gate_ex_hold_ctr
// Brief    : Modulo-HOLD cycle counter with a terminal-count flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_ex_hold_ctr
  import gate_ex_pkg::*;
#(
  parameter int HOLD = C_DEFAULT_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int C_CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [C_CNT_W-1:0] C_TC_VAL = C_CNT_W'(HOLD - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               w_tc;

  assign w_tc = (r_cnt == C_TC_VAL);
  assign tc   = w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gate_vector_exerciser.sv
//------------------------------------------------------------------------------
// Module   : gate_vector_exerciser
// Brief    : Drives all input vectors to a gate under test in ascending order,
//            checks each response against the AND reduction, reports result.
//            Define GATE_EX_FIRST_FAIL_EN to add fail_vec/fail_seen capture.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_vector_exerciser
  import gate_ex_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int HOLD  = C_DEFAULT_HOLD,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef GATE_EX_FIRST_FAIL_EN
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_seen,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

  gate_ex_state_e   r_state;
  gate_ex_state_e   w_next_state;
  logic [WIDTH-1:0] r_vec;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_next;
  logic             r_pass;
  logic             w_launch;
  logic             w_tc;
  logic             w_compare;
  logic             w_mismatch;
  logic             w_last;

  // Start is honoured only outside an active run.
  assign w_launch   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_compare  = (r_state == ST_DRIVE) && w_tc;
  assign w_mismatch = w_compare && (dut_y != f_and_reduce(32'(r_vec), WIDTH));
  assign w_last     = w_compare && (&r_vec);
  assign w_err_next = (w_mismatch && (r_err != C_ERR_MAX)) ? r_err + 1'b1 : r_err;

  gate_ex_hold_ctr #(
    .HOLD (HOLD)
  ) u_hold_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_launch),
    .en    (r_state == ST_DRIVE),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_launch) w_next_state = ST_DRIVE;
      ST_DRIVE: if (w_last)   w_next_state = ST_DONE;
      ST_DONE:  if (w_launch) w_next_state = ST_DRIVE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_launch) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_compare) begin
      r_err <= w_err_next;
      r_vec <= w_last ? '0 : r_vec + 1'b1;
      // Pass must include the mismatch detected on the final compare edge.
      if (w_last) r_pass <= (w_err_next == '0);
    end
  end

`ifdef GATE_EX_FIRST_FAIL_EN
  logic [WIDTH-1:0] r_fail_vec;
  logic             r_fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_vec  <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_launch) begin
      r_fail_vec  <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_mismatch && !r_fail_seen) begin
      r_fail_vec  <= r_vec;
      r_fail_seen <= 1'b1;
    end
  end

  assign fail_vec  = r_fail_vec;
  assign fail_seen = r_fail_seen;
`endif

  assign vec_out = r_vec;
  assign busy    = (r_state == ST_DRIVE);
  assign done    = (r_state == ST_DONE);
  assign pass    = r_pass;
  assign err_cnt = r_err;

endmodule

`default_nettype wire

// File: doc/gate_vector_exerciser.md
Name: gate_vector_exerciser

Overview:
- Synthesizable stimulus/response stage that sits directly upstream of the two-input gate under test and also consumes that gate's output.
- Drives every input combination in ascending binary order and holds each for HOLD cycles.
- Samples the gate output at the end of each hold window and compares it against the expected AND reduction.
- Reports an error count and a pass/done status, replacing the hand-written #-delay stimulus with a cycle-accurate hardware sequencer.

Parameters:
- WIDTH, 2, number of gate inputs driven; vector space is 2**WIDTH.
- HOLD, 3, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE or DONE.
- vec_out  output  WIDTH  input vector driven to the gate under test (bit0 = a, bit1 = b).
- dut_y  input  1  gate-under-test output.
- busy  output  1  high while vectors are being driven.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid when done=1; high iff err_cnt==0.
- err_cnt  output  ERR_W  mismatches in the current or last run; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - vec_out=0, busy=0, done=0, pass=0, err_cnt=0.
  - hold counter=0.
- States: IDLE, DRIVE, DONE.
- IDLE: start=1 at edge k moves to DRIVE. At that edge: vec_out=0, hold_cnt=0, err_cnt=0, busy=1.
- DRIVE:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD-1, dut_y is compared with &vec_out at that edge. A mismatch increments err_cnt, saturating.
  - At that same edge hold_cnt returns to 0 and vec_out increments.
- Last vector: if vec_out is all-ones at the compare edge, vec_out returns to 0 and state goes to DONE. busy=0, done=1, and pass reflects the final err_cnt, including the final compare.
- Latency: done rises at edge k + (2**WIDTH)*HOLD. For the defaults that is 12 cycles after the start edge.
- start while in DRIVE is ignored; the run is not restarted.
- DONE: outputs hold. start=1 behaves exactly as in IDLE: done=0, counters clear, new run.
- dut_y is sampled with no internal resynchronisation. The gate under test must be combinational or settle within HOLD-1 cycles.
- Vector wrap uses WIDTH-bit unsigned arithmetic. The all-ones detect terminates the run, so no vector repeats.
- Saturation: once err_cnt is all-ones it holds; pass stays 0.
- Reset mid-run: immediate return to IDLE with all reset values; the partial run is discarded.
- HOLD=1: a compare happens every cycle and vec_out changes every cycle.

Optional Feature:
- Macro: GATE_EX_FIRST_FAIL_EN.
- When defined, two extra output ports exist:
  - fail_vec (WIDTH): vector of the first mismatch in the run.
  - fail_seen (1): set on the first mismatch.
- Both are captured once per run, cleared at start and at reset, and unaffected by later mismatches.
- When undefined, neither port nor its flops exist. All other behaviour is identical.

Decomposition:
- Shared package gate_ex_pkg holds:
  - the state enum (IDLE/DRIVE/DONE);
  - the expected-function helper (AND reduction of a WIDTH-bit vector);
  - a default HOLD constant.
- One natural sub-module, gate_ex_hold_ctr: parameterised hold counter with a terminal-count flag, used by the FSM.
- The comparator stays inline.

Test Plan:
- Correct AND gate, defaults, start pulse at cycle 2 -> vec_out 00,01,10,11 each for 3 cycles; done=1 and pass=1 at cycle 14; err_cnt=0.
- dut_y tied 0 -> only vector 11 fails; err_cnt=1, pass=0; with GATE_EX_FIRST_FAIL_EN, fail_vec=2'b11, fail_seen=1.
- dut_y tied 1 -> vectors 00,01,10 fail; err_cnt=3; fail_vec=2'b00.
- start re-pulsed mid-DRIVE, then rst_n low for 1 cycle during vector 10 -> no restart on start; reset forces vec_out=0, busy=0, err_cnt=0 asynchronously; a later start runs normally to pass=1.
- WIDTH=3, ERR_W=2, dut_y tied 1 -> 7 mismatches; err_cnt saturates at 3; done after 24 cycles.
- After a pass, second start from DONE with dut_y tied 0 -> done drops on the start edge, err_cnt clears, then ends with err_cnt=1.
